// File: rtl/fpu_issue_ctrl_if.sv
// ============================================================================
// Module      : fpu_issue_ctrl_if
// Description : Request, FPU-side and response signal bundle for fpu_issue_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fpu_issue_ctrl_if #(
    parameter int TAG_W = 5
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic             req_sel;
    logic [31:0]      req_rs1;
    logic [31:0]      req_rs2;
    logic [TAG_W-1:0] req_tag;
    logic             flush;
    logic [31:0]      fpu_rs1;
    logic [31:0]      fpu_rs2;
    logic [1:0]       fpu_control;
    logic             fpu_sel;
    logic [31:0]      fpu_result;
    logic             resp_valid;
    logic             resp_ready;
    logic [31:0]      resp_data;
    logic [TAG_W-1:0] resp_tag;
    logic             busy;

    // Pipeline / FPU / writeback side
    modport master (
        output req_valid, req_op, req_sel, req_rs1, req_rs2, req_tag, flush,
        output fpu_result, resp_ready,
        input  req_ready, fpu_rs1, fpu_rs2, fpu_control, fpu_sel,
        input  resp_valid, resp_data, resp_tag, busy
    );

    // Controller side
    modport slave (
        input  req_valid, req_op, req_sel, req_rs1, req_rs2, req_tag, flush,
        input  fpu_result, resp_ready,
        output req_ready, fpu_rs1, fpu_rs2, fpu_control, fpu_sel,
        output resp_valid, resp_data, resp_tag, busy
    );
endinterface

`default_nettype wire

// File: rtl/fpu_issue_ctrl.sv
// ============================================================================
// Module      : fpu_issue_ctrl
// Description : Multi-cycle issue sequencer holding operands on a combinational
//               FPU for an op-dependent latency, then presenting the result.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_issue_ctrl #(
    parameter int TAG_W      = 5,
    parameter int ADDSUB_LAT = 2,
    parameter int MUL_LAT    = 3,
    parameter int DIV_LAT    = 8,
    parameter int SQRT_LAT   = 8
) (
    input  wire logic           clk,
    input  wire logic           rst,
    fpu_issue_ctrl_if.slave     bus
);

    localparam int c_max_lat =
        (ADDSUB_LAT >= MUL_LAT && ADDSUB_LAT >= DIV_LAT && ADDSUB_LAT >= SQRT_LAT) ? ADDSUB_LAT :
        (MUL_LAT >= DIV_LAT && MUL_LAT >= SQRT_LAT) ? MUL_LAT :
        (DIV_LAT >= SQRT_LAT) ? DIV_LAT : SQRT_LAT;
    localparam int c_cnt_w = (c_max_lat > 1) ? $clog2(c_max_lat) : 1;

    localparam logic [c_cnt_w-1:0] c_addsub_m1 = c_cnt_w'(ADDSUB_LAT - 1);
    localparam logic [c_cnt_w-1:0] c_mul_m1    = c_cnt_w'(MUL_LAT - 1);
    localparam logic [c_cnt_w-1:0] c_div_m1    = c_cnt_w'(DIV_LAT - 1);
    localparam logic [c_cnt_w-1:0] c_sqrt_m1   = c_cnt_w'(SQRT_LAT - 1);

    generate
        if (ADDSUB_LAT < 1 || MUL_LAT < 1 || DIV_LAT < 1 || SQRT_LAT < 1) begin : g_lat_check
            $error("fpu_issue_ctrl: every LAT parameter must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        c_idle = 2'd0,
        c_exec = 2'd1,
        c_done = 2'd2
    } state_t;

    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [31:0]        r_fpu_rs1;
    logic [31:0]        r_fpu_rs2;
    logic [1:0]         r_fpu_control;
    logic               r_fpu_sel;
    logic [TAG_W-1:0]   r_tag;
    logic [31:0]        r_resp_data;
    logic [TAG_W-1:0]   r_resp_tag;
    logic               r_resp_valid;
    logic               r_busy;

    logic               w_req_ready;
    logic               w_accept;
    logic [c_cnt_w-1:0] w_lat_m1;

    // A new op may only enter while idle or in the very cycle the old result retires.
    assign w_req_ready = !bus.flush &&
                         ((r_state == c_idle) || ((r_state == c_done) && bus.resp_ready));
    assign w_accept    = bus.req_valid && w_req_ready;

    always_comb begin
        w_lat_m1 = c_addsub_m1;
        case (bus.req_op)
            2'b00:   w_lat_m1 = c_addsub_m1;
            2'b01:   w_lat_m1 = c_mul_m1;
            2'b10:   w_lat_m1 = c_div_m1;
            default: w_lat_m1 = c_sqrt_m1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_idle;
            r_cnt         <= '0;
            r_fpu_rs1     <= '0;
            r_fpu_rs2     <= '0;
            r_fpu_control <= '0;
            r_fpu_sel     <= 1'b0;
            r_tag         <= '0;
            r_resp_data   <= '0;
            r_resp_tag    <= '0;
            r_resp_valid  <= 1'b0;
            r_busy        <= 1'b0;
        end else if (bus.flush) begin
            r_state      <= c_idle;
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else if (w_accept) begin
            // Covers both a fresh issue from idle and a back-to-back issue at retire.
            r_fpu_rs1     <= bus.req_rs1;
            r_fpu_rs2     <= bus.req_rs2;
            r_fpu_control <= bus.req_op;
            r_fpu_sel     <= bus.req_sel;
            r_tag         <= bus.req_tag;
            r_cnt         <= w_lat_m1;
            r_state       <= c_exec;
            r_resp_valid  <= 1'b0;
            r_busy        <= 1'b1;
        end else begin
            case (r_state)
                c_exec: begin
                    if (r_cnt == '0) begin
                        r_resp_data  <= bus.fpu_result;
                        r_resp_tag   <= r_tag;
                        r_state      <= c_done;
                        r_resp_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_done: begin
                    if (bus.resp_ready) begin
                        r_state      <= c_idle;
                        r_resp_valid <= 1'b0;
                        r_busy       <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    assign bus.req_ready   = w_req_ready;
    assign bus.fpu_rs1     = r_fpu_rs1;
    assign bus.fpu_rs2     = r_fpu_rs2;
    assign bus.fpu_control = r_fpu_control;
    assign bus.fpu_sel     = r_fpu_sel;
    assign bus.resp_valid  = r_resp_valid;
    assign bus.resp_data   = r_resp_data;
    assign bus.resp_tag    = r_resp_tag;
    assign bus.busy        = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_fpu_issue_ctrl.sv
// ============================================================================
// Module      : tb_fpu_issue_ctrl
// Description : Self-checking bench with a real-arithmetic FPU stub and a
//               timestamp-based transaction model of the issue controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpu_issue_ctrl;

    localparam int TAG_W      = 5;
    localparam int ADDSUB_LAT = 2;
    localparam int MUL_LAT    = 3;
    localparam int DIV_LAT    = 8;
    localparam int SQRT_LAT   = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fpu_issue_ctrl_if #(.TAG_W(TAG_W)) bus ();

    fpu_issue_ctrl #(
        .TAG_W     (TAG_W),
        .ADDSUB_LAT(ADDSUB_LAT),
        .MUL_LAT   (MUL_LAT),
        .DIV_LAT   (DIV_LAT),
        .SQRT_LAT  (SQRT_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Single-precision <-> real conversion for normal numbers and zero.
    function automatic real s2r(input logic [31:0] b);
        logic [10:0] e;
        if (b[30:0] == 31'd0) return 0.0;
        e = {3'b000, b[30:23]} + 11'd896;
        return $bitstoreal({b[31], e, b[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2s(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fpu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [1:0] op, input logic sel);
        real ra, rb;
        ra = s2r(a);
        rb = s2r(b);
        case (op)
            2'b00:   return r2s(sel ? ra - rb : ra + rb);
            2'b01:   return r2s(ra * rb);
            2'b10:   return r2s(ra / rb);
            default: return r2s($sqrt(ra));
        endcase
    endfunction

    function automatic int lat_of(input logic [1:0] op);
        case (op)
            2'b00:   return ADDSUB_LAT;
            2'b01:   return MUL_LAT;
            2'b10:   return DIV_LAT;
            default: return SQRT_LAT;
        endcase
    endfunction

    assign bus.fpu_result = fpu_model(bus.fpu_rs1, bus.fpu_rs2, bus.fpu_control, bus.fpu_sel);

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Transaction model: one outstanding op, ready at a known cycle stamp.
    int               cyc = 0;
    bit               m_pending = 1'b0;
    int               m_done_cyc = 0;
    logic [31:0]      m_data = '0;
    logic [TAG_W-1:0] m_tag = '0;
    logic [31:0]      m_rs1 = '0, m_rs2 = '0;
    logic [1:0]       m_ctl = '0;
    logic             m_sel = 1'b0;

    task automatic step();
        bit exp_rv, exp_rdy, acc, ret;
        @(negedge clk);
        exp_rv  = m_pending && (cyc >= m_done_cyc);
        exp_rdy = !bus.flush && (!m_pending || (exp_rv && bus.resp_ready));
        if (!rst) begin
            chk("req_ready",   64'(bus.req_ready),   64'(exp_rdy));
            chk("busy",        64'(bus.busy),        64'(m_pending));
            chk("resp_valid",  64'(bus.resp_valid),  64'(exp_rv));
            chk("fpu_rs1",     64'(bus.fpu_rs1),     64'(m_rs1));
            chk("fpu_rs2",     64'(bus.fpu_rs2),     64'(m_rs2));
            chk("fpu_control", 64'(bus.fpu_control), 64'(m_ctl));
            chk("fpu_sel",     64'(bus.fpu_sel),     64'(m_sel));
            if (exp_rv) begin
                chk("resp_data", 64'(bus.resp_data), 64'(m_data));
                chk("resp_tag",  64'(bus.resp_tag),  64'(m_tag));
            end
        end
        acc = !rst && bus.req_valid && exp_rdy;
        ret = exp_rv && bus.resp_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            m_pending = 1'b0;
            m_rs1 = '0; m_rs2 = '0; m_ctl = '0; m_sel = 1'b0;
        end else if (bus.flush) begin
            m_pending = 1'b0;
        end else begin
            if (ret) m_pending = 1'b0;
            if (acc) begin
                m_pending  = 1'b1;
                m_done_cyc = cyc + lat_of(bus.req_op);
                m_rs1 = bus.req_rs1; m_rs2 = bus.req_rs2;
                m_ctl = bus.req_op;  m_sel = bus.req_sel;
                m_tag = bus.req_tag;
                m_data = fpu_model(bus.req_rs1, bus.req_rs2, bus.req_op, bus.req_sel);
            end
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic sel,
                         input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag);
        bus.req_valid = v;
        bus.req_op    = op;
        bus.req_sel   = sel;
        bus.req_rs1   = a;
        bus.req_rs2   = b;
        bus.req_tag   = tag;
    endtask

    function automatic logic [31:0] rnd_fp();
        return r2s(real'($urandom_range(1, 64)));
    endfunction

    initial begin
        rst = 1'b1;
        bus.flush = 1'b0;
        bus.resp_ready = 1'b1;
        drive(1'b1, 2'b01, 1'b0, 32'h3F800000, 32'h40000000, 5'd1);
        repeat (2) step();

        // Reset release
        rst = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        chk("rst_busy",    64'(bus.busy),        64'd0);
        chk("rst_rvalid",  64'(bus.resp_valid),  64'd0);
        chk("rst_ready",   64'(bus.req_ready),   64'd1);
        chk("rst_rs1",     64'(bus.fpu_rs1),     64'd0);
        chk("rst_rs2",     64'(bus.fpu_rs2),     64'd0);
        chk("rst_ctl",     64'(bus.fpu_control), 64'd0);
        chk("rst_sel",     64'(bus.fpu_sel),     64'd0);
        chk("rst_rdata",   64'(bus.resp_data),   64'd0);
        step();

        // ADD 1.0 + 2.0, latency 2
        drive(1'b1, 2'b00, 1'b0, 32'h3F800000, 32'h40000000, 5'd7);
        step();
        bus.req_valid = 1'b0;
        chk("add_rv_e0", 64'(bus.resp_valid), 64'd0);
        step();
        chk("add_rv_e1", 64'(bus.resp_valid), 64'd0);
        step();
        chk("add_rv_e2", 64'(bus.resp_valid), 64'd1);
        chk("add_data",  64'(bus.resp_data),  64'h40400000);
        chk("add_tag",   64'(bus.resp_tag),   64'd7);
        step();
        chk("add_idle",  64'(bus.busy),       64'd0);

        // DIV 10 / 2 with backpressure
        bus.resp_ready = 1'b0;
        drive(1'b1, 2'b10, 1'b0, 32'h41200000, 32'h40000000, 5'd3);
        step();
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b00;
        repeat (DIV_LAT) step();
        for (int i = 0; i < 5; i++) begin
            chk("div_rv",    64'(bus.resp_valid), 64'd1);
            chk("div_data",  64'(bus.resp_data),  64'h40A00000);
            chk("div_ready", 64'(bus.req_ready),  64'd0);
            chk("div_busy",  64'(bus.busy),       64'd1);
            step();
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        step();
        chk("div_retire", 64'(bus.resp_valid), 64'd0);

        // Back-to-back: ADD held in DONE, MUL accepted on the retire edge
        bus.resp_ready = 1'b0;
        drive(1'b1, 2'b00, 1'b1, 32'h40A00000, 32'h3F800000, 5'd4);
        step();
        bus.req_valid = 1'b0;
        repeat (ADDSUB_LAT) step();
        bus.resp_ready = 1'b1;
        drive(1'b1, 2'b01, 1'b0, 32'h40400000, 32'h40800000, 5'd9);
        #1;
        chk("b2b_ready", 64'(bus.req_ready), 64'd1);
        step();
        bus.req_valid = 1'b0;
        chk("b2b_busy",  64'(bus.busy),       64'd1);
        chk("b2b_ctl",   64'(bus.fpu_control), 64'd1);
        repeat (MUL_LAT) step();
        chk("mul_rv",    64'(bus.resp_valid), 64'd1);
        chk("mul_data",  64'(bus.resp_data),  64'h41400000);
        chk("mul_tag",   64'(bus.resp_tag),   64'd9);
        step();

        // Flush during SQRT
        drive(1'b1, 2'b11, 1'b0, 32'h41800000, 32'h40000000, 5'd12);
        step();
        bus.req_valid = 1'b0;
        repeat (3) step();
        bus.flush = 1'b1;
        drive(1'b1, 2'b01, 1'b0, 32'h40000000, 32'h40000000, 5'd2);
        #1;
        chk("flush_ready", 64'(bus.req_ready), 64'd0);
        step();
        bus.flush = 1'b0;
        bus.req_valid = 1'b0;
        chk("flush_busy", 64'(bus.busy),        64'd0);
        chk("flush_ctl",  64'(bus.fpu_control), 64'd3);
        for (int i = 0; i < 10; i++) begin
            chk("flush_rv", 64'(bus.resp_valid), 64'd0);
            step();
        end

        // Operand stability while the request bus churns during EXEC
        drive(1'b1, 2'b10, 1'b0, 32'h42000000, 32'h40800000, 5'd21);
        step();
        for (int i = 0; i < DIV_LAT + 2; i++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom));
            bus.resp_ready = 1'b0;
            chk("stab_rs1", 64'(bus.fpu_rs1), 64'h42000000);
            step();
        end
        chk("stab_data", 64'(bus.resp_data), 64'h41000000);
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        step();

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom), 1'($urandom),
                  rnd_fp(), rnd_fp(), 5'($urandom));
            bus.resp_ready = ($urandom_range(0, 3) != 0);
            bus.flush      = ($urandom_range(0, 31) == 0);
            step();
        end
        bus.flush = 1'b0;
        bus.req_valid = 1'b0;
        bus.resp_ready = 1'b1;
        repeat (12) step();
        chk("final_idle", 64'(bus.busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
- Multi-cycle sequencer between the integer/FP pipeline's execute stage and the combinational FPU datapath.
- Accepts one FP operation per request using a valid/ready handshake. It registers the operands and holds them stable on the FPU inputs for an operation-dependent number of cycles. It then captures the result and presents it with a tag until the writeback side accepts it.
- Drives a busy/stall indication so the pipeline can freeze while DIV/SQRT settle.

Parameters:
- TAG_W, 5, width of destination-register tag carried alongside the operation.
- ADDSUB_LAT, 2, cycles the FPU inputs are held before capture for op 2'b00 (min 1).
- MUL_LAT, 3, hold cycles for op 2'b01 (min 1).
- DIV_LAT, 8, hold cycles for op 2'b10 (min 1).
- SQRT_LAT, 8, hold cycles for op 2'b11 (min 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_op  in  2  00 ADDSUB, 01 MUL, 10 DIV, 11 SQRT.
- req_sel  in  1  add/sub select, forwarded to the FPU sel input.
- req_rs1  in  32  operand A (single-precision).
- req_rs2  in  32  operand B (ignored by SQRT but still registered).
- req_tag  in  TAG_W  destination tag.
- flush  in  1  discard the in-flight operation and any pending result.
- fpu_rs1  out  32  registered operand A to the FPU.
- fpu_rs2  out  32  registered operand B to the FPU.
- fpu_control  out  2  registered op to the FPU.
- fpu_sel  out  1  registered sel to the FPU.
- fpu_result  in  32  combinational FPU result.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts the result.
- resp_data  out  32  captured result.
- resp_tag  out  TAG_W  tag of the captured result.
- busy  out  1  state != IDLE.

Behaviour:
- All state changes occur on the rising edge of clk. rst is sampled synchronously and overrides every other input.
- Reset values: state=IDLE, cnt=0, fpu_rs1=fpu_rs2=0, fpu_control=00, fpu_sel=0, resp_data=0, resp_tag=0, resp_valid=0, busy=0.
- States: IDLE, EXEC, DONE. resp_valid = (state==DONE). busy = (state!=IDLE).
- req_ready = !flush && (state==IDLE || (state==DONE && resp_ready)). It is combinational and may depend on resp_ready in the same cycle.
- Accept = req_valid && req_ready at an edge. On accept:
  - the fpu_* registers load req_rs1/rs2/op/sel;
  - the tag register loads req_tag;
  - cnt loads LAT(req_op)-1;
  - state goes to EXEC.
- EXEC: the fpu_* registers hold. At each edge, if cnt==0, resp_data is loaded from fpu_result, resp_tag from the held tag, and state goes to DONE; otherwise cnt decrements.
- Latency: if the accept edge is E, resp_valid is first high after edge E+LAT. With LAT=1, resp_valid is high after E+1.
- DONE: resp_data/resp_tag are stable while resp_valid=1 and resp_ready=0. When resp_ready=1 at an edge, the result retires; state goes to EXEC if an accept occurs at that same edge (back-to-back), else IDLE.
- In IDLE and DONE the fpu_* registers keep their last values. There is no toggling without a request.
- flush=1 at an edge from any state:
  - state goes to IDLE and resp_valid drops;
  - no capture occurs;
  - no accept occurs, because req_ready is forced low;
  - a result retired at that edge is dropped.
- Changes to req_* while not accepting have no effect. Operands are never re-sampled during EXEC.
- A result that is not yet retired is never overwritten. A new operation can only be accepted in the cycle the old result retires.
- cnt width is clog2 of the maximum LAT, with a minimum of 1 bit. A LAT parameter below 1 is illegal (elaboration-time check).

Test Plan:
- Reset: assert rst for 2 cycles with req_valid=1 -> after release, busy=0, resp_valid=0, req_ready=1, and all fpu_* outputs are 0.
- ADD: rs1=0x3F800000, rs2=0x40000000, op=00, sel=0, tag=7, resp_ready=1, ADDSUB_LAT=2 -> resp_valid high exactly 2 edges after accept, resp_data=0x40400000, resp_tag=7, then IDLE.
- DIV backpressure: 0x41200000 / 0x40000000, op=10, resp_ready=0 for 5 cycles after valid -> resp_valid and data 0x40A00000 held for all 5 cycles, req_ready=0, busy=1, then one-cycle retire.
- Back-to-back: in DONE with resp_ready=1 and req_valid=1 (MUL 0x40400000*0x40800000) -> the previous result retires and the MUL is accepted at the same edge. The MUL produces 0x41400000 MUL_LAT edges later with no bubble in the handshake.
- Flush: accept SQRT 0x41800000, assert flush at the 4th EXEC cycle -> next cycle is IDLE, resp_valid never rises, and req_valid held high that cycle is not accepted.
- Operand stability: toggle req_rs1 randomly during EXEC -> fpu_rs1 stays constant, and the captured result corresponds to the operands sampled at accept.
